rng_arbiter: RTL and testbench
==============================

# rng_arbiter

Sequencer and round-robin arbiter for the shared 32-bit random number generator in the Monte Carlo datapath. After reset, and whenever a reseed is requested, it loads a seed into the generator and discards a programmable number of warm-up outputs. It then hands each generator output to at most one of NREQ requesters, so no two consumers ever receive the same draw.

## Interface
Parameters:
- NREQ, 4: number of requesters, 2..16.
- WARMUP, 16: generator outputs discarded after each seed load, 0..65535.
- SEED_DEFAULT, 32'h12345678: seed loaded after reset.

Ports:
- clk  in  1  system clock. Rising edge only.
- rst  in  1  reset. **Synchronous and active-high.**
- reseed_i  in  1  request a reseed. seed_i is sampled on the same edge.
- seed_i  in  32  seed value captured when reseed_i=1.
- rng_number_i  in  32  generator output. The generator advances one step per clk while not loading.
- rng_loadseed_o  out  1  load strobe to the generator.
- rng_seed_o  out  32  seed presented to the generator.
- req_i  in  NREQ  per-requester level request.
- gnt_o  out  NREQ  registered one-hot grant, one cycle wide.
- number_o  out  32  registered random number for the granted requester.
- valid_o  out  1  number_o/gnt_o valid (equals |gnt_o).
- ready_o  out  1  high when in RUN.

## Operation
- FSM states:
  - SEED: rng_loadseed_o=1. Next state is WARMUP, or RUN when WARMUP=0. The warm-up counter loads WARMUP.
  - WARMUP: counter decrements each cycle and generator outputs are ignored. Leaves to RUN on the edge where counter==1, so exactly WARMUP cycles are spent in WARMUP.
  - RUN: arbitrate each cycle.
- rng_loadseed_o = (state==SEED) and ready_o = (state==RUN). Both are Moore decodes with no combinational path from inputs.
- Seed register:
  - Loads SEED_DEFAULT on rst.
  - Loads seed_i on any edge with reseed_i=1 in any state.
  - Drives rng_seed_o continuously.
- Reseed:
  - reseed_i=1 at an edge sends state to SEED from any state, including SEED and WARMUP, which restarts warm-up.
  - That edge issues no grant. gnt_o and valid_o are 0 the following cycle.
- Round-robin pointer:
  - Holds the index of the last granted requester. Reset value is NREQ-1, so requester 0 has first priority.
  - On an edge in RUN with reseed_i=0 and |req_i=1, grant the first asserted requester searching from pointer+1 upward, with modulo-NREQ wrap.
  - On that edge: gnt_o ← one-hot(index), number_o ← rng_number_i, valid_o ← 1, pointer ← index.
- No request, or state not RUN:
  - gnt_o←0 and valid_o←0.
  - number_o holds its last value.
  - Pointer unchanged.
- A requester holding req_i high may be granted on consecutive cycles if it is the only one requesting.
- Grants are never queued. A request is served only on an edge where it is asserted.
- Every delivered number is the generator output of a distinct clock cycle. No number is delivered twice.
- Pointer and seed register are not reset by reseed; only rst resets them.

## Timing
- Reset values (after an edge with rst=1):
  - state=SEED, so rng_loadseed_o=1.
  - rng_seed_o=SEED_DEFAULT.
  - gnt_o=0, valid_o=0, number_o=0, ready_o=0.
- rst dominates reseed_i and req_i on the same edge.
- rst asserted mid-grant clears gnt_o and valid_o on that edge.
- First cycle after rst falls: SEED (1 cycle). Then WARMUP cycles, then RUN.
  - ready_o rises WARMUP+1 cycles after the first post-reset cycle.
  - The first grant can appear one cycle after that.
- Grant latency: req_i sampled at edge k → gnt_o/valid_o/number_o valid during cycle k+1, for exactly one cycle.
- Throughput: one grant per cycle in RUN.
- Reseed latency: reseed_i at edge k → rng_loadseed_o=1 and ready_o=0 during cycle k+1. RUN resumes after SEED plus WARMUP cycles.

## Test plan
- Reset, WARMUP=16, req_i=0 → rng_loadseed_o=1 with rng_seed_o=32'h12345678 for 1 cycle. Then ready_o=0 for 16 cycles, then ready_o=1. valid_o stays 0 throughout.
- NREQ=4, req_i=4'b1111 held in RUN → gnt_o sequence 0001,0010,0100,1000,0001 on consecutive cycles. Each number_o equals rng_number_i at the granting edge, and no value repeats.
- req_i=4'b0100 only, held 5 cycles → gnt_o=0100 on 5 consecutive cycles. Then req_i=4'b1001 → grants 1000 then 0001, since the pointer was at 2 and the search starts at 3.
- Reseed in RUN with seed_i=32'hDEADBEEF while req_i=4'b0001 → no grant in the next cycle. rng_loadseed_o=1 with rng_seed_o=32'hDEADBEEF, ready_o low for 1+WARMUP cycles, then grants resume.
- Reseed asserted again during WARMUP → warm-up restarts: a full WARMUP cycles elapse after the new SEED cycle before ready_o=1.
- WARMUP=0 build → SEED for 1 cycle, then RUN immediately. rst asserted while gnt_o=0010 → gnt_o=0, valid_o=0, number_o=0 next cycle, and the pointer restarts at requester 0.

Source files
------------

// File: rtl/rng_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rng_arbiter
//  Description : Seeds and warms up the shared 32-bit RNG, then hands each
//                generator draw to at most one requester (round-robin).
//  Revision    : 1.0 - initial release
// ============================================================================
module rng_arbiter #(
    parameter int          NREQ         = 4,
    parameter int          WARMUP       = 16,
    parameter logic [31:0] SEED_DEFAULT = 32'h12345678
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            reseed_i,
    input  logic [31:0]     seed_i,
    input  logic [31:0]     rng_number_i,
    output logic            rng_loadseed_o,
    output logic [31:0]     rng_seed_o,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [31:0]     number_o,
    output logic            valid_o,
    output logic            ready_o
);

    localparam int              c_PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [1:0]      c_ST_SEED  = 2'd0;
    localparam logic [1:0]      c_ST_WARM  = 2'd1;
    localparam logic [1:0]      c_ST_RUN   = 2'd2;
    localparam logic [c_PW-1:0] c_PTR_RST  = c_PW'(NREQ - 1);
    localparam logic [c_PW:0]   c_NREQ_W   = (c_PW + 1)'(NREQ);
    localparam logic [15:0]     c_WARM_LD  = 16'(WARMUP);

    logic [1:0]      r_state;
    logic [15:0]     r_cnt;
    logic [31:0]     r_seed;
    logic [c_PW-1:0] r_ptr;
    logic [NREQ-1:0] r_gnt;
    logic [31:0]     r_num;
    logic            r_valid;

    logic [2*NREQ-1:0] w_req2;
    logic [NREQ-1:0]   w_rot;
    logic [c_PW:0]     w_shamt;
    logic [c_PW:0]     w_sum;
    logic [c_PW:0]     w_wrap;
    logic [c_PW-1:0]   w_off;
    logic [c_PW-1:0]   w_idx;
    logic              w_found;
    logic [NREQ-1:0]   w_onehot;

    // Rotate requests so bit 0 is the requester just after the pointer.
    assign w_req2  = {req_i, req_i};
    assign w_shamt = {1'b0, r_ptr} + (c_PW + 1)'(1);
    assign w_rot   = NREQ'(w_req2 >> w_shamt);

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_off   = k[c_PW-1:0];
            end
        end
    end

    assign w_sum    = w_shamt + {1'b0, w_off};
    assign w_wrap   = w_sum - c_NREQ_W;
    assign w_idx    = (w_sum >= c_NREQ_W) ? w_wrap[c_PW-1:0] : w_sum[c_PW-1:0];
    assign w_onehot = NREQ'(1) << w_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_SEED;
            r_cnt   <= '0;
            r_seed  <= SEED_DEFAULT;
            r_ptr   <= c_PTR_RST;
            r_gnt   <= '0;
            r_num   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_gnt   <= '0;
            r_valid <= 1'b0;
            if (reseed_i) begin
                r_seed  <= seed_i;
                r_state <= c_ST_SEED;
            end else begin
                case (r_state)
                    c_ST_SEED: begin
                        r_cnt   <= c_WARM_LD;
                        r_state <= (WARMUP == 0) ? c_ST_RUN : c_ST_WARM;
                    end
                    c_ST_WARM: begin
                        r_cnt <= r_cnt - 16'd1;
                        if (r_cnt == 16'd1) r_state <= c_ST_RUN;
                    end
                    c_ST_RUN: begin
                        if (w_found) begin
                            r_gnt   <= w_onehot;
                            r_num   <= rng_number_i;
                            r_valid <= 1'b1;
                            r_ptr   <= w_idx;
                        end
                    end
                    default: r_state <= c_ST_SEED;
                endcase
            end
        end
    end

    assign rng_loadseed_o = (r_state == c_ST_SEED);
    assign ready_o        = (r_state == c_ST_RUN);
    assign rng_seed_o     = r_seed;
    assign gnt_o          = r_gnt;
    assign number_o       = r_num;
    assign valid_o        = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_rng_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rng_arbiter
//  Description : Scoreboard bench for rng_arbiter (WARMUP=16 and WARMUP=0).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rng_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst = 1'b1, a_reseed = 1'b0;
    logic [31:0] a_seed = '0;
    logic [3:0]  a_req = '0;
    logic [31:0] rng = 32'h0BAD_5EED;
    logic        a_load, a_valid, a_ready;
    logic [31:0] a_seedo, a_num;
    logic [3:0]  a_gnt;

    logic        b_rst = 1'b1, b_reseed = 1'b0;
    logic [31:0] b_seed = '0;
    logic [3:0]  b_req = '0;
    logic        b_load, b_valid, b_ready;
    logic [31:0] b_seedo, b_num;
    logic [3:0]  b_gnt;

    rng_arbiter #(.NREQ(4), .WARMUP(16), .SEED_DEFAULT(32'h12345678)) u_a (
        .clk(clk), .rst(a_rst), .reseed_i(a_reseed), .seed_i(a_seed),
        .rng_number_i(rng), .rng_loadseed_o(a_load), .rng_seed_o(a_seedo),
        .req_i(a_req), .gnt_o(a_gnt), .number_o(a_num), .valid_o(a_valid),
        .ready_o(a_ready));

    rng_arbiter #(.NREQ(4), .WARMUP(0), .SEED_DEFAULT(32'h12345678)) u_b (
        .clk(clk), .rst(b_rst), .reseed_i(b_reseed), .seed_i(b_seed),
        .rng_number_i(rng), .rng_loadseed_o(b_load), .rng_seed_o(b_seedo),
        .req_i(b_req), .gnt_o(b_gnt), .number_o(b_num), .valid_o(b_valid),
        .ready_o(b_ready));

    typedef logic [70:0] obs_t;
    obs_t        sb[$];
    obs_t        obs, exp_obs;
    logic [31:0] seen[$];
    int          errors = 0, checks = 0;

    int          m_state, m_cnt, m_ptr;
    logic [31:0] m_seed, m_num;
    logic [3:0]  m_gnt;
    logic        m_valid;

    task automatic tick();
        @(posedge clk);
        #1;
        rng = rng * 32'd1664525 + 32'd1013904223;
    endtask

    // Behavioural model of instance A; expected outputs queued before the edge.
    task automatic edge_a();
        obs_t e;
        if (a_rst) begin
            m_state = 0; m_seed = 32'h12345678; m_ptr = 3;
            m_gnt = '0; m_valid = 1'b0; m_num = '0;
        end else begin
            m_gnt = '0; m_valid = 1'b0;
            if (a_reseed) begin
                m_seed = a_seed; m_state = 0;
            end else if (m_state == 0) begin
                m_cnt = 16; m_state = 1;
            end else if (m_state == 1) begin
                if (m_cnt == 1) m_state = 2;
                m_cnt--;
            end else begin
                for (int k = 1; k <= 4; k++) begin
                    int j;
                    j = (m_ptr + k) % 4;
                    if (a_req[j] && !m_valid) begin
                        m_ptr = j; m_gnt = 4'(1 << j); m_valid = 1'b1; m_num = rng;
                    end
                end
            end
        end
        e = {m_gnt, m_valid, m_num, m_state == 0, m_state == 2, m_seed};
        sb.push_back(e);
        tick();
        obs     = {a_gnt, a_valid, a_num, a_load, a_ready, a_seedo};
        exp_obs = sb.pop_front();
    endtask

    task automatic test_reset();
        int  low;
        logic got;
        a_rst = 1'b1; a_req = '0; a_reseed = 1'b0;
        edge_a();
        checks++;
        if (obs !== exp_obs) begin errors++; $display("FAIL reset_model got=%h exp=%h", obs, exp_obs); end
        checks++;
        if ({a_load, a_seedo, a_gnt, a_valid, a_num, a_ready} !== {1'b1, 32'h12345678, 4'b0, 1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got load=%b seed=%h gnt=%b valid=%b num=%h ready=%b exp 1 12345678 0000 0 0 0",
                     a_load, a_seedo, a_gnt, a_valid, a_num, a_ready);
        end
        a_rst = 1'b0; low = 0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            edge_a();
            checks++;
            if (obs !== exp_obs) begin errors++; $display("FAIL warmup_model got=%h exp=%h", obs, exp_obs); end
            if (a_ready) got = 1'b1; else low++;
        end
        checks++;
        if (!got || low != 16) begin errors++; $display("FAIL warmup_len got=%0d ready=%b exp=16", low, got); end
    endtask

    task automatic test_round_robin();
        logic [3:0]  seq[5];
        logic [31:0] n;
        int          dup;
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        a_req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            n = rng;
            edge_a();
            checks++;
            if (obs !== exp_obs) begin errors++; $display("FAIL rr_model got=%h exp=%h", obs, exp_obs); end
            checks++;
            if (a_gnt !== seq[i] || a_num !== n || a_valid !== 1'b1) begin
                errors++;
                $display("FAIL rr_seq[%0d] got gnt=%b num=%h valid=%b exp gnt=%b num=%h valid=1", i, a_gnt, a_num, a_valid, seq[i], n);
            end
            dup = 0;
            foreach (seen[q]) if (seen[q] === a_num) dup++;
            checks++;
            if (dup != 0) begin errors++; $display("FAIL rr_unique got repeats=%0d of %h exp=0", dup, a_num); end
            seen.push_back(a_num);
        end
    endtask

    task automatic test_single_then_pair();
        logic [31:0] n;
        a_req = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            n = rng;
            edge_a();
            checks++;
            if (obs !== exp_obs) begin errors++; $display("FAIL single_model got=%h exp=%h", obs, exp_obs); end
            checks++;
            if (a_gnt !== 4'b0100 || a_num !== n) begin
                errors++; $display("FAIL single[%0d] got gnt=%b num=%h exp gnt=0100 num=%h", i, a_gnt, a_num, n);
            end
        end
        a_req = 4'b1001;
        edge_a();
        checks++;
        if (a_gnt !== 4'b1000 || obs !== exp_obs) begin errors++; $display("FAIL pair_first got gnt=%b exp=1000", a_gnt); end
        edge_a();
        checks++;
        if (a_gnt !== 4'b0001 || obs !== exp_obs) begin errors++; $display("FAIL pair_second got gnt=%b exp=0001", a_gnt); end
    endtask

    task automatic test_idle();
        logic [31:0] held;
        held  = a_num;
        a_req = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            edge_a();
            checks++;
            if (a_gnt !== 4'b0 || a_valid !== 1'b0 || a_num !== held || obs !== exp_obs) begin
                errors++; $display("FAIL idle[%0d] got gnt=%b valid=%b num=%h exp 0000 0 %h", i, a_gnt, a_valid, a_num, held);
            end
        end
    endtask

    task automatic test_reseed(input logic warm_restart);
        int   low;
        logic got;
        a_req = warm_restart ? 4'b0000 : 4'b0001;
        a_reseed = 1'b1; a_seed = 32'hDEADBEEF;
        edge_a();
        a_reseed = 1'b0;
        checks++;
        if ({a_gnt, a_valid, a_load, a_ready, a_seedo} !== {4'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF} || obs !== exp_obs) begin
            errors++; $display("FAIL reseed_edge got gnt=%b valid=%b load=%b ready=%b seed=%h exp 0000 0 1 0 deadbeef",
                               a_gnt, a_valid, a_load, a_ready, a_seedo);
        end
        if (warm_restart) begin
            for (int i = 0; i < 5; i++) edge_a();
            a_reseed = 1'b1; a_seed = 32'hCAFEF00D;
            edge_a();
            a_reseed = 1'b0; a_req = 4'b0001;
            checks++;
            if (a_load !== 1'b1 || a_seedo !== 32'hCAFEF00D || obs !== exp_obs) begin
                errors++; $display("FAIL rewarm_edge got load=%b seed=%h exp 1 cafef00d", a_load, a_seedo);
            end
        end
        low = 1; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            edge_a();
            checks++;
            if (obs !== exp_obs || a_valid !== 1'b0) begin errors++; $display("FAIL reseed_model got=%h exp=%h", obs, exp_obs); end
            if (a_ready) got = 1'b1; else low++;
        end
        checks++;
        if (!got || low != 17) begin errors++; $display("FAIL reseed_not_ready got=%0d ready=%b exp=17", low, got); end
        edge_a();
        checks++;
        if (a_gnt !== 4'b0001 || a_valid !== 1'b1 || obs !== exp_obs) begin
            errors++; $display("FAIL reseed_resume got gnt=%b valid=%b exp 0001 1", a_gnt, a_valid);
        end
    endtask

    task automatic test_warmup0();
        checks++;
        if (b_load !== 1'b1 || b_ready !== 1'b0) begin errors++; $display("FAIL w0_seed got load=%b ready=%b exp 1 0", b_load, b_ready); end
        b_rst = 1'b0; b_req = 4'b0000;
        tick();
        checks++;
        if (b_load !== 1'b0 || b_ready !== 1'b1) begin errors++; $display("FAIL w0_run got load=%b ready=%b exp 0 1", b_load, b_ready); end
        b_req = 4'b0011;
        tick();
        checks++;
        if (b_gnt !== 4'b0001) begin errors++; $display("FAIL w0_g0 got=%b exp=0001", b_gnt); end
        tick();
        checks++;
        if (b_gnt !== 4'b0010 || b_valid !== 1'b1) begin errors++; $display("FAIL w0_g1 got=%b exp=0010", b_gnt); end
        b_rst = 1'b1;
        tick();
        checks++;
        if ({b_gnt, b_valid, b_num, b_load} !== {4'b0, 1'b0, 32'h0, 1'b1}) begin
            errors++; $display("FAIL w0_rst got gnt=%b valid=%b num=%h load=%b exp 0000 0 0 1", b_gnt, b_valid, b_num, b_load);
        end
        b_rst = 1'b0; b_req = 4'b1111;
        tick();
        checks++;
        if (b_gnt !== 4'b0000 || b_ready !== 1'b1) begin errors++; $display("FAIL w0_rerun got gnt=%b ready=%b exp 0000 1", b_gnt, b_ready); end
        tick();
        checks++;
        if (b_gnt !== 4'b0001) begin errors++; $display("FAIL w0_ptr_restart got=%b exp=0001", b_gnt); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_then_pair();
        test_idle();
        test_reseed(1'b0);
        test_reseed(1'b1);
        test_warmup0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
